// File: rtl/rcc_test_mode_seq.sv
// Test clock/reset mux select sequencer: steps testmode and scan_mode in and
// out of scan test with functional clocks gated around every select change.
module rcc_test_mode_seq #(
    parameter int SETTLE_CYC = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test_req,
    output logic             test_ack,
    output logic             testmode,
    output logic             scan_mode,
    output logic             func_clk_en,
    output logic             busy,
    output logic [2:0]       seq_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        TMODE  = 3'd2,
        SCAN   = 3'd3,
        ACTIVE = 3'd4,
        XGATE  = 3'd5,
        XSCAN  = 3'd6,
        XTMODE = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             expired_s;
    logic [4:0]       out_r;

    // Output pattern {func_clk_en, testmode, scan_mode, test_ack, busy} per state
    function automatic logic [4:0] decode(input state_t s);
        logic [4:0] v;
        case (s)
            IDLE:    v = 5'b1_0_0_0_0;
            GATE:    v = 5'b0_0_0_0_1;
            TMODE:   v = 5'b0_1_0_0_1;
            SCAN:    v = 5'b0_1_1_0_1;
            ACTIVE:  v = 5'b1_1_1_1_0;
            XGATE:   v = 5'b0_1_1_0_1;
            XSCAN:   v = 5'b0_1_0_0_1;
            XTMODE:  v = 5'b0_0_0_0_1;
            default: v = 5'b1_0_0_0_0;
        endcase
        return v;
    endfunction

    assign expired_s = (cnt_r == CNT_ZERO);

    // Next-state and settle-counter logic
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (test_req) begin
                    next_state_s = GATE;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    cnt_next_s   = CNT_ZERO;
                end
            end
            ACTIVE: begin
                if (!test_req) begin
                    next_state_s = XGATE;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    cnt_next_s   = CNT_ZERO;
                end
            end
            GATE, TMODE, XGATE, XSCAN: begin
                if (expired_s) begin
                    cnt_next_s = CNT_LOAD;
                    case (state_r)
                        GATE:    next_state_s = TMODE;
                        TMODE:   next_state_s = SCAN;
                        XGATE:   next_state_s = XSCAN;
                        XSCAN:   next_state_s = XTMODE;
                        default: next_state_s = IDLE;
                    endcase
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            SCAN, XTMODE: begin
                if (expired_s) begin
                    next_state_s = (state_r == SCAN) ? ACTIVE : IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and outputs registered together so outputs never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            out_r   <= 5'b1_0_0_0_0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            out_r   <= decode(next_state_s);
        end
    end

    assign func_clk_en = out_r[4];
    assign testmode    = out_r[3];
    assign scan_mode   = out_r[2];
    assign test_ack    = out_r[1];
    assign busy        = out_r[0];
    assign seq_state   = state_r;

endmodule

// File: tb/tb_rcc_test_mode_seq.sv
// Directed bench for rcc_test_mode_seq with S=4 and S=1 instances and an
// invariant monitor over random test_req.
module tb_rcc_test_mode_seq;

    logic       clk;
    logic       rst;
    logic       req4, req1;
    logic       ack4, tm4, sm4, fen4, busy4;
    logic       ack1, tm1, sm1, fen1, busy1;
    logic [2:0] st4, st1;

    int total;
    int bad;
    bit mon_en;

    rcc_test_mode_seq #(.SETTLE_CYC(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .test_req(req4), .test_ack(ack4),
        .testmode(tm4), .scan_mode(sm4), .func_clk_en(fen4),
        .busy(busy4), .seq_state(st4)
    );

    rcc_test_mode_seq #(.SETTLE_CYC(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .test_req(req1), .test_ack(ack1),
        .testmode(tm1), .scan_mode(sm1), .func_clk_en(fen1),
        .busy(busy1), .seq_state(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Spec table: {state, func_clk_en, testmode, scan_mode, test_ack, busy}
    function automatic logic [7:0] exp_vec(input logic [2:0] st);
        logic [4:0] o;
        case (st)
            3'd0:    o = 5'b10000;
            3'd1:    o = 5'b00001;
            3'd2:    o = 5'b01001;
            3'd3:    o = 5'b01101;
            3'd4:    o = 5'b11110;
            3'd5:    o = 5'b01101;
            3'd6:    o = 5'b01001;
            default: o = 5'b00001;
        endcase
        return {st, o};
    endfunction

    function automatic logic [7:0] obs4();
        return {st4, fen4, tm4, sm4, ack4, busy4};
    endfunction

    function automatic logic [7:0] obs1();
        return {st1, fen1, tm1, sm1, ack1, busy1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariant monitor: prev values always tracked, checks only when enabled
    logic p_tm4, p_sm4, p_fen4, p_tm1, p_sm1, p_fen1;
    task automatic inv(input string tag, input logic tm, input logic sm, input logic fen,
                       input logic ptm, input logic psm, input logic pfen);
        check({tag, "_scan_wo_tm"}, {31'd0, sm & ~tm}, 32'd0);
        if ((tm != ptm) || (sm != psm)) begin
            check({tag, "_both_sel"}, {31'd0, (tm != ptm) && (sm != psm)}, 32'd0);
            check({tag, "_fen_chg"}, {31'd0, fen}, 32'd0);
            check({tag, "_fen_prev"}, {31'd0, pfen}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            inv("inv4", tm4, sm4, fen4, p_tm4, p_sm4, p_fen4);
            inv("inv1", tm1, sm1, fen1, p_tm1, p_sm1, p_fen1);
        end
        p_tm4 <= tm4; p_sm4 <= sm4; p_fen4 <= fen4;
        p_tm1 <= tm1; p_sm1 <= sm1; p_fen1 <= fen1;
    end

    initial begin
        int busy_cnt;
        logic [2:0] es;
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        req4   = 1'b0;
        req1   = 1'b0;

        // 1. reset values before any clock edge, then idle hold
        #2;
        check("rst_async4", {24'd0, obs4()}, {24'd0, exp_vec(3'd0)});
        check("rst_async1", {24'd0, obs1()}, {24'd0, exp_vec(3'd0)});
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_hold", {24'd0, obs4()}, {24'd0, exp_vec(3'd0)});
        end

        // 2. entry, S=4
        req4 = 1'b1;
        busy_cnt = 0;
        for (int e = 0; e < 16; e++) begin
            step();
            es = (e < 4) ? 3'd1 : (e < 8) ? 3'd2 : (e < 12) ? 3'd3 : 3'd4;
            check($sformatf("entry_e%0d", e), {24'd0, obs4()}, {24'd0, exp_vec(es)});
            busy_cnt += int'(busy4);
        end
        check("entry_busy_cnt", busy_cnt, 32'd12);

        // 3. exit, S=4
        req4 = 1'b0;
        for (int e = 0; e < 16; e++) begin
            step();
            es = (e < 4) ? 3'd5 : (e < 8) ? 3'd6 : (e < 12) ? 3'd7 : 3'd0;
            check($sformatf("exit_e%0d", e), {24'd0, obs4()}, {24'd0, exp_vec(es)});
        end

        // 4. request dropped during entry
        req4 = 1'b1;
        for (int e = 0; e < 27; e++) begin
            step();
            es = (e < 4)  ? 3'd1 : (e < 8)  ? 3'd2 : (e < 12) ? 3'd3 :
                 (e == 12) ? 3'd4 : (e < 17) ? 3'd5 : (e < 21) ? 3'd6 :
                 (e < 25) ? 3'd7 : 3'd0;
            check($sformatf("drop_e%0d", e), {24'd0, obs4()}, {24'd0, exp_vec(es)});
            if (e == 6) req4 = 1'b0;
        end

        // S=1 boundary: one cycle per step, and request raised during exit
        req1 = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            es = (e < 3) ? 3'(e + 1) : 3'd4;
            check($sformatf("s1_entry_e%0d", e), {24'd0, obs1()}, {24'd0, exp_vec(es)});
        end
        req1 = 1'b0;
        step();
        check("s1_xgate", {24'd0, obs1()}, {24'd0, exp_vec(3'd5)});
        req1 = 1'b1;
        for (int e = 1; e < 6; e++) begin
            step();
            es = (e == 1) ? 3'd6 : (e == 2) ? 3'd7 : (e == 3) ? 3'd0 : (e == 4) ? 3'd1 : 3'd2;
            check($sformatf("s1_reentry_e%0d", e), {24'd0, obs1()}, {24'd0, exp_vec(es)});
        end

        // 5. random requests with invariant monitor on both instances
        mon_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) req4 = ~req4;
            if ($urandom_range(0, 2) == 0) req1 = ~req1;
        end
        mon_en = 1'b0;

        // 6. reset asserted in SCAN, restart from GATE
        req4 = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("pre6_idle", {24'd0, obs4()}, {24'd0, exp_vec(3'd0)});
        req4 = 1'b1;
        for (int e = 0; e < 10; e++) step();
        check("in_scan", {24'd0, obs4()}, {24'd0, exp_vec(3'd3)});
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_scan", {24'd0, obs4()}, {24'd0, exp_vec(3'd0)});
        @(negedge clk);
        check("rst_hold", {24'd0, obs4()}, {24'd0, exp_vec(3'd0)});
        rst = 1'b0;
        step();
        check("restart_gate", {24'd0, obs4()}, {24'd0, exp_vec(3'd1)});
        step();
        check("restart_gate2", {24'd0, obs4()}, {24'd0, exp_vec(3'd1)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
